sevenseg_mux_driver: RTL and testbench

Parametrised multi-digit seven-segment driver: accepts an unsigned binary value through a load/busy handshake. It converts the value to BCD with a sequential shift-add-3 (double-dabble) engine, then time-multiplexes the digits onto one shared segment bus with one-hot digit enables. It is the next generation of the single-digit decimal decoder, and sits between application logic and the board's multiplexed seven-segment display pins.

---
 rtl/sevenseg_mux_driver.sv | 222 ++++++++++++++++++++++
 tb/tb_sevenseg_mux_driver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_mux_driver.sv
// Multi-digit seven-segment driver: sequential double-dabble BCD conversion plus time-multiplexed scan.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_mux_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value_bin,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam int unsigned BCD_W     = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ITER_W    = $clog2(BIN_W + 1);
    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    // Active-low {a,b,c,d,e,f,g} glyph for one decimal digit
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  w_accept;
    logic                  w_last;

    logic [BIN_W-1:0]      r_bin;
    logic [BCD_W-1:0]      r_bcd;
    logic                  r_ovf_pend;
    logic [ITER_W-1:0]     r_iter;
    logic [BCD_W-1:0]      w_bcd_adj;
    logic [BCD_W-1:0]      w_bcd_shift;
    logic [BIN_W-1:0]      w_bin_shift;

    logic [BCD_W-1:0]      r_disp;
    logic                  r_disp_ovf;

    logic [CNT_W-1:0]      r_refresh;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_wrap;
    logic                  r_scan_on;

    logic [NUM_DIGITS-1:0] w_blank;
    logic [3:0]            w_digit;
    logic                  w_blank_sel;
    logic [6:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    // Conversion control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (r_iter == ITER_W'(BIN_W - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_CONV);

    // One double-dabble step: add 3 to each nibble >= 5, then shift {bcd, bin} left
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        {w_bcd_shift, w_bin_shift} = {w_bcd_adj, r_bin} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_ovf_pend <= 1'b0;
            r_iter     <= '0;
            r_disp     <= '0;
            r_disp_ovf <= 1'b0;
        end else if (w_accept) begin
            r_bin      <= value_bin;
            r_bcd      <= '0;
            r_ovf_pend <= (64'(value_bin) >= OVF_LIMIT);
            r_iter     <= '0;
        end else if (r_state == S_CONV) begin
            r_bin  <= w_bin_shift;
            r_bcd  <= w_bcd_shift;
            r_iter <= r_iter + ITER_W'(1);
            // Display only ever takes a finished conversion, digits and flag together
            if (w_last) begin
                r_disp     <= w_bcd_shift;
                r_disp_ovf <= r_ovf_pend;
            end
        end
    end

    assign w_wrap = (r_refresh == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Scan timing runs freely; loads never disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_idx     <= IDX_W'(NUM_DIGITS - 1);
            r_scan_on <= 1'b0;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + CNT_W'(1);
            r_idx     <= w_idx_nxt;
            r_scan_on <= r_scan_on | w_wrap;
        end
    end

`ifdef SEVENSEG_LZB_EN
    // A digit is blank when it and every more significant digit are zero; digit 0 never blanks
    always_comb begin
        w_blank = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            w_blank[i] = ((r_disp >> (4 * i)) == '0);
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_digit     = 4'd0;
        w_blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_digit     = r_disp[4*i +: 4];
                w_blank_sel = w_blank[i];
            end
        end
        if (r_disp_ovf) begin
            w_seg_nxt = SEG_DASH;
        end else if (w_blank_sel) begin
            w_seg_nxt = SEG_BLANK;
        end else begin
            w_seg_nxt = digit_to_seg(w_digit);
        end
        w_an_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
    end

    // Pins stay dark until the first refresh wrap, then follow the index every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else if (w_wrap || r_scan_on) begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Self-checking bench for sevenseg_mux_driver against an arithmetic model of digits and scan timing.
`timescale 1ns/1ps
module tb_sevenseg_mux_driver;

    localparam int unsigned N   = 4;
    localparam int unsigned BW  = 14;
    localparam int unsigned REF = 1000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_TBL [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                            7'b0000000, 7'b0000100};
`ifdef SEVENSEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [BW-1:0] value_bin = '0;
    logic          busy;
    logic [6:0]    seg;
    logic [N-1:0]  an;

    int unsigned t;
    int n_vec = 0;
    int n_err = 0;

    sevenseg_mux_driver #(.NUM_DIGITS(N), .BIN_W(BW), .REFRESH_DIV(REF)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_bin(value_bin),
        .busy(busy), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Edges elapsed since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    function automatic int unsigned p10(int unsigned n);
        int unsigned p = 1;
        for (int unsigned k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(int unsigned v, int unsigned d);
        if (v >= p10(N)) return SEG_DASH;
        if (LZB && d > 0 && v < p10(d)) return SEG_BLANK;
        return SEG_TBL[(v / p10(d)) % 10];
    endfunction

    function automatic int unsigned slot_of(int unsigned tt);
        return ((tt - REF) / REF) % N;
    endfunction

    function automatic logic [N-1:0] exp_an(int unsigned tt);
        if (tt < REF) return '1;
        return ~(N'(1) << slot_of(tt));
    endfunction

    function automatic logic [6:0] exp_seg_at(int unsigned v, int unsigned tt);
        if (tt < REF) return SEG_BLANK;
        return exp_seg(v, slot_of(tt));
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_load(int unsigned v);
        load = 1'b1;
        value_bin = BW'(v);
        tick();
        load = 1'b0;
    endtask

    // Advance to the middle of the next window in which digit d is enabled
    task automatic goto_slot(int unsigned d);
        for (int k = 0; k < int'((N + 2) * REF); k++) begin
            if (t >= REF && slot_of(t) == d && (t - REF) % REF == REF / 2) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (busy !== 1'b0 || seg !== SEG_BLANK || an !== '1) begin
            n_err++;
            $display("FAIL reset_init: busy=%b seg=%b an=%b, required 0 %b %b", busy, seg, an, SEG_BLANK, {N{1'b1}});
        end
        rst_n = 1'b1;
        repeat (REF + 200) tick();
        pulse_load(3210);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || seg !== SEG_BLANK || an !== '1) begin
            n_err++;
            $display("FAIL reset_async: busy=%b seg=%b an=%b, required 0 %b %b", busy, seg, an, SEG_BLANK, {N{1'b1}});
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_first_scan();
        for (int k = 0; k < int'((N + 1) * REF + 2); k++) begin
            tick();
            n_vec++;
            if (an !== exp_an(t) || seg !== exp_seg_at(0, t)) begin
                n_err++;
                $display("FAIL first_scan t=%0d: an=%b seg=%b, required an=%b seg=%b", t, an, seg, exp_an(t), exp_seg_at(0, t));
                break;
            end
        end
    endtask

    task automatic test_load_1234();
        int unsigned v = 1234;
        pulse_load(v);
        for (int k = 0; k < int'(BW); k++) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_high cycle %0d: busy=%b, required 1", k, busy);
            end
            tick();
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_fall: busy=%b, required 0", busy);
        end
        n_vec++;
        if (seg !== exp_seg_at(0, t)) begin
            n_err++;
            $display("FAIL seg_old_at_fall: seg=%b, required %b", seg, exp_seg_at(0, t));
        end
        tick();
        n_vec++;
        if (seg !== exp_seg_at(v, t)) begin
            n_err++;
            $display("FAIL seg_new_latency: seg=%b, required %b", seg, exp_seg_at(v, t));
        end
        for (int unsigned d = 0; d < N; d++) begin
            goto_slot(d);
            n_vec++;
            if (an !== exp_an(t) || seg !== exp_seg(v, d)) begin
                n_err++;
                $display("FAIL load_1234 digit %0d: an=%b seg=%b, required an=%b seg=%b", d, an, seg, exp_an(t), exp_seg(v, d));
            end
        end
    endtask

    task automatic test_overflow();
        int unsigned vals [2] = '{12000, 9999};
        foreach (vals[j]) begin
            pulse_load(vals[j]);
            repeat (BW + 2) tick();
            for (int unsigned d = 0; d < N; d++) begin
                goto_slot(d);
                n_vec++;
                if (an !== exp_an(t) || seg !== exp_seg(vals[j], d)) begin
                    n_err++;
                    $display("FAIL overflow v=%0d digit %0d: an=%b seg=%b, required an=%b seg=%b", vals[j], d, an, seg, exp_an(t), exp_seg(vals[j], d));
                end
            end
        end
    endtask

    task automatic test_load_during_busy();
        int unsigned v = 5678;
        pulse_load(v);
        repeat (4) tick();
        pulse_load(1111);
        repeat (8) tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_load_busy13: busy=%b, required 1", busy);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_load_busy14: busy=%b, required 0", busy);
        end
        tick();
        for (int unsigned d = 0; d < N; d++) begin
            goto_slot(d);
            n_vec++;
            if (an !== exp_an(t) || seg !== exp_seg(v, d)) begin
                n_err++;
                $display("FAIL load_during_busy digit %0d: an=%b seg=%b, required an=%b seg=%b", d, an, seg, exp_an(t), exp_seg(v, d));
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned a = $urandom_range(0, 9999);
        int unsigned b = $urandom_range(0, 9999);
        pulse_load(a);
        repeat (BW) tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first_done: busy=%b, required 0", busy);
        end
        load = 1'b1;
        value_bin = BW'(b);
        tick();
        load = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_accept: busy=%b, required 1", busy);
        end
        repeat (BW + 1) tick();
        for (int unsigned d = 0; d < N; d++) begin
            goto_slot(d);
            n_vec++;
            if (an !== exp_an(t) || seg !== exp_seg(b, d)) begin
                n_err++;
                $display("FAIL back_to_back v=%0d digit %0d: an=%b seg=%b, required an=%b seg=%b", b, d, an, seg, exp_an(t), exp_seg(b, d));
            end
        end
    endtask

    task automatic test_lzb();
        int unsigned vals [2] = '{7, 0};
        foreach (vals[j]) begin
            pulse_load(vals[j]);
            repeat (BW + 2) tick();
            for (int unsigned d = 0; d < N; d++) begin
                goto_slot(d);
                n_vec++;
                if (an !== exp_an(t) || seg !== exp_seg(vals[j], d)) begin
                    n_err++;
                    $display("FAIL lzb v=%0d digit %0d: an=%b seg=%b, required an=%b seg=%b", vals[j], d, an, seg, exp_an(t), exp_seg(vals[j], d));
                end
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        pulse_load(4321);
        repeat (6) tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midconv_busy: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || seg !== SEG_BLANK || an !== '1) begin
            n_err++;
            $display("FAIL midconv_reset: busy=%b seg=%b an=%b, required 0 %b %b", busy, seg, an, SEG_BLANK, {N{1'b1}});
        end
        tick();
        rst_n = 1'b1;
        for (int unsigned d = 0; d < N; d++) begin
            goto_slot(d);
            n_vec++;
            if (an !== exp_an(t) || seg !== exp_seg(0, d)) begin
                n_err++;
                $display("FAIL midconv_after digit %0d: an=%b seg=%b, required an=%b seg=%b", d, an, seg, exp_an(t), exp_seg(0, d));
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 4; j++) begin
            int unsigned v;
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, (1 << BW) - 1);
            endcase
            repeat ($urandom_range(0, 20)) tick();
            pulse_load(v);
            repeat (BW + 1) tick();
            for (int unsigned d = 0; d < N; d++) begin
                goto_slot(d);
                n_vec++;
                if (an !== exp_an(t) || seg !== exp_seg(v, d)) begin
                    n_err++;
                    $display("FAIL random v=%0d digit %0d: an=%b seg=%b, required an=%b seg=%b", v, d, an, seg, exp_an(t), exp_seg(v, d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_load_1234();
        test_overflow();
        test_load_during_busy();
        test_back_to_back();
        test_lzb();
        test_reset_mid_conv();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
